// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the FIFO burst reader: FSM state encoding and counter sizing helper.
package fifo_burst_reader_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Width of a counter that must hold values 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_skid_buf2.sv
// Two-entry valid/ready skid buffer with a registered head; strict FIFO order.
module fifo_skid_buf2 #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic [1:0]       count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] tail_q;
    logic [1:0]       count_q;
    logic             pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign count     = count_q;

    // A push while full is never issued by the owner, so it is not handled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push) begin
                        head_q  <= push_data;
                        count_q <= 2'd1;
                    end
                end
                2'd1: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q  <= push_data;
                            count_q <= 2'd2;
                        end
                        2'b01:   count_q <= 2'd0;
                        2'b11:   head_q  <= push_data;
                        default: ;
                    endcase
                end
                2'd2: begin
                    if (pop) begin
                        head_q <= tail_q;
                        if (push) begin
                            tail_q <= push_data;
                        end else begin
                            count_q <= 2'd1;
                        end
                    end
                end
                default: count_q <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-domain consumer: pops FIFO words in fixed-length bursts and re-emits them as a
// valid/ready stream through a 2-entry skid buffer.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_LEN  = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  en,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [CNT_WIDTH-1:0]  words_read,
    output logic                  idle
);

    localparam int unsigned BW = cnt_bits(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } entry_t;

    logic [0:0]    state;
    logic [0:0]    state_next;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_cnt_next;
    logic [1:0]    occupancy;
    logic          run;
    logic          at_last;
    entry_t        push_entry;
    entry_t        head_entry;

    assign run     = (state == ST_BURST) | ((state == ST_IDLE) & en);
    // Pop decision looks only at registered occupancy, keeping m_ready off this path.
    assign rinc    = rrst_n & run & ~empty & (occupancy < 2'd2);
    assign at_last = (beat_cnt == LAST_BEAT);

    assign push_entry = '{data: rdata, last: at_last};

    always_comb begin
        state_next    = state;
        beat_cnt_next = beat_cnt;
        if (rinc) begin
            if (at_last) begin
                beat_cnt_next = '0;
                state_next    = en ? ST_BURST : ST_IDLE;
            end else begin
                beat_cnt_next = beat_cnt + BW'(1);
                state_next    = ST_BURST;
            end
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= ST_IDLE;
            beat_cnt   <= '0;
            words_read <= '0;
        end else begin
            state    <= state_next;
            beat_cnt <= beat_cnt_next;
            if (rinc) begin
                words_read <= words_read + CNT_WIDTH'(1);
            end
        end
    end

    fifo_skid_buf2 #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_skid (
        .clk      (rclk),
        .rst_n    (rrst_n),
        .push     (rinc),
        .push_data(push_entry),
        .count    (occupancy),
        .out_valid(m_valid),
        .out_ready(m_ready),
        .out_data (head_entry)
    );

    assign m_data = head_entry.data;
    assign m_last = head_entry.last;
    assign idle   = (state == ST_IDLE) & (occupancy == 2'd0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader: table-driven cycle vectors plus multi-cycle sequences.
module tb_fifo_burst_reader;
    import fifo_burst_reader_pkg::*;

    logic        rclk    = 1'b0;
    logic        rrst_n  = 1'b1;
    logic        en      = 1'b0;
    logic        m_ready = 1'b0;
    logic        empty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic [15:0] words_read;
    logic        idle;

    logic        en2      = 1'b0;
    logic        empty2   = 1'b0;
    logic        m_ready2 = 1'b1;
    logic [7:0]  rdata2   = 8'h00;
    logic        rinc2;
    logic        m_valid2;
    logic [7:0]  m_data2;
    logic        m_last2;
    logic [3:0]  words_read2;
    logic        idle2;

    // FIFO model: first-word-fall-through head, popped on rinc edges.
    logic [7:0] fifo_mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;

    assign empty = (wr_ptr == rd_ptr);
    assign rdata = fifo_mem[rd_ptr[7:0]];

    always @(posedge rclk) if (rinc) rd_ptr <= rd_ptr + 1;
    always @(posedge rclk) if (rinc2) rdata2 <= rdata2 + 8'd1;

    always #5 rclk = ~rclk;

    fifo_burst_reader #(
        .DATA_WIDTH(8),
        .BURST_LEN (4),
        .CNT_WIDTH (16)
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .en        (en),
        .empty     (empty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .words_read(words_read),
        .idle      (idle)
    );

    fifo_burst_reader #(
        .DATA_WIDTH(8),
        .BURST_LEN (1),
        .CNT_WIDTH (4)
    ) dut_wrap (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .en        (en2),
        .empty     (empty2),
        .rdata     (rdata2),
        .rinc      (rinc2),
        .m_valid   (m_valid2),
        .m_ready   (m_ready2),
        .m_data    (m_data2),
        .m_last    (m_last2),
        .words_read(words_read2),
        .idle      (idle2)
    );

    typedef struct {
        logic       en;
        logic       rdy;
        logic       rinc;
        logic       valid;
        logic [7:0] data;
        logic       last;
        logic       idle;
    } vec_t;

    vec_t       tbl [0:13];
    logic [7:0] exp_d [0:7];
    logic       exp_l [0:7];
    int         pass_cnt  = 0;
    int         total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(posedge rclk);
        #1;
    endtask

    task automatic load(input logic [7:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            fifo_mem[wr_ptr[7:0]] = first + 8'(i);
            wr_ptr++;
        end
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            en      = tbl[i].en;
            m_ready = tbl[i].rdy;
            step();
            check($sformatf("vec%0d rinc", i), 32'(rinc), 32'(tbl[i].rinc));
            check($sformatf("vec%0d valid", i), 32'(m_valid), 32'(tbl[i].valid));
            check($sformatf("vec%0d idle", i), 32'(idle), 32'(tbl[i].idle));
            if (tbl[i].valid) begin
                check($sformatf("vec%0d data", i), 32'(m_data), 32'(tbl[i].data));
                check($sformatf("vec%0d last", i), 32'(m_last), 32'(tbl[i].last));
            end
        end
    endtask

    // Collects n handshaken beats against exp_d/exp_l, bounded by a cycle budget.
    task automatic collect(input int n);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 60) begin
            if (m_valid && m_ready) begin
                check($sformatf("beat%0d data", got), 32'(m_data), 32'(exp_d[got]));
                check($sformatf("beat%0d last", got), 32'(m_last), 32'(exp_l[got]));
                got++;
            end
            step();
            cyc++;
        end
        if (got < n) check("collect timeout", got, n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;

        // Streaming: 0x11..0x18, en dropped during the second burst.
        tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h13, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h14, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h16, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h17, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h18, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
        // en drop after beat 1 with 10 words queued.
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h31, 1'b0, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h32, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'h34, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};

        for (int i = 0; i < 256; i++) fifo_mem[i] = 8'h00;

        rrst_n = 1'b0;
        #1;
        check("reset idle", 32'(idle), 1);
        check("reset valid", 32'(m_valid), 0);
        check("reset rinc", 32'(rinc), 0);
        check("reset words_read", 32'(words_read), 0);
        check("reset m_data", 32'(m_data), 0);
        check("reset m_last", 32'(m_last), 0);
        @(negedge rclk);
        rrst_n = 1'b1;
        step();

        load(8'h11, 8);
        run_tbl(0, 8);
        check("stream words_read", 32'(words_read), 8);

        // Backpressure: only two pops may happen while m_ready is low.
        m_ready = 1'b0;
        load(8'h21, 6);
        en = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (!m_valid || m_data !== 8'h21) bad++;
        end
        check("bp head held", bad, 0);
        check("bp rinc", 32'(rinc), 0);
        check("bp words_read", 32'(words_read), 10);
        check("bp fifo left", wr_ptr - rd_ptr, 4);
        check("bp occupancy", 32'(dut.occupancy), 2);
        for (int i = 0; i < 6; i++) begin
            exp_d[i] = 8'h21 + 8'(i);
            exp_l[i] = (i == 3);
        end
        m_ready = 1'b1;
        collect(6);
        check("bp words_read after", 32'(words_read), 14);

        // Starvation: FIFO ran dry two beats into a burst.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rinc || m_valid) bad++;
        end
        check("starve quiet", bad, 0);
        check("starve state", 32'(dut.state), 32'(ST_BURST));
        check("starve beat_cnt", 32'(dut.beat_cnt), 2);
        check("starve idle", 32'(idle), 0);
        en = 1'b0;
        exp_d[0] = 8'h27;
        exp_l[0] = 1'b0;
        exp_d[1] = 8'h28;
        exp_l[1] = 1'b1;
        load(8'h27, 2);
        collect(2);
        check("starve done idle", 32'(idle), 1);
        check("starve words_read", 32'(words_read), 16);

        load(8'h31, 10);
        run_tbl(9, 13);
        check("endrop fifo left", wr_ptr - rd_ptr, 6);
        check("endrop state", 32'(dut.state), 32'(ST_IDLE));

        // Reset asserted mid-burst with the skid buffer full.
        m_ready = 1'b0;
        en = 1'b1;
        step();
        step();
        check("pre-reset occupancy", 32'(dut.occupancy), 2);
        check("pre-reset state", 32'(dut.state), 32'(ST_BURST));
        #2;
        rrst_n = 1'b0;
        #1;
        check("async reset valid", 32'(m_valid), 0);
        check("async reset rinc", 32'(rinc), 0);
        check("async reset words_read", 32'(words_read), 0);
        check("async reset idle", 32'(idle), 1);
        en = 1'b0;
        m_ready = 1'b1;
        @(negedge rclk);
        rrst_n = 1'b1;
        step();

        // Counter wrap and single-beat bursts on the CNT_WIDTH=4, BURST_LEN=1 instance.
        en2 = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            step();
            if (k == 1) check("len1 last", 32'(m_valid2 & m_last2), 1);
            if (k == 15) check("wrap pop15", 32'(words_read2), 15);
            if (k == 16) check("wrap pop16", 32'(words_read2), 0);
            if (k == 17) check("wrap pop17", 32'(words_read2), 1);
        end
        en2 = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
